mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one 8-to-1 multiplexer among eight requesters. It drives the mux select lines S2..S0 and a one-hot grant vector. Ownership is held for a bounded tenure, and handover between owners has no bubble cycle. It sits directly in front of the multiplexer_8_to_1 select inputs in the single-cycle datapath.

## Interface
- MAX_HOLD, default 4: maximum contested tenure in cycles; legal range is 1..15.
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  arbitration enable; when low, no new grants are issued and the current owner is released
- REQ  in  8  request vector; REQ[i] is held high by requester i while it needs the mux
- GNT  out  8  one-hot grant, registered; 0x00 when no owner
- S2, S1, S0  out  1 each  registered mux select, equal to the owner index (S2 = MSB)
- BUSY  out  1  high while any grant is active

## Operation
- State: FSM {IDLE, OWN}, PTR[2:0] (priority start), OWN_IDX[2:0], CNT (4 bits).
- Circular pick: the search order is PTR, PTR+1, ..., 7, 0, ..., PTR-1, all mod 8. The winner is the first set bit of the masked request vector.
- IDLE, with EN=1 and REQ≠0:
  - Next edge: state goes to OWN, OWN_IDX and S take the winner, GNT=onehot(winner), CNT=1, BUSY=1.
- OWN, owner o. Release at the next edge if any of these holds:
  - REQ[o]=0;
  - EN=0;
  - CNT==MAX_HOLD and some REQ[j]=1 with j≠o (preemption).
- On release:
  - PTR takes o+1 mod 8, so 7 wraps to 0.
  - If EN=1 and any REQ[j]=1 with j≠o: grant the circular pick from o+1 at the same edge (back-to-back), with CNT=1.
  - Otherwise: GNT=0x00, BUSY=0, state goes to IDLE.
- A preempted owner that keeps REQ high is lowest priority and waits its turn.
- OWN with no release condition: hold the grant; CNT increments and saturates at MAX_HOLD. Uncontested owners never lose the grant.
- S2..S0 keep the last owner index while IDLE; the mux input stays selected but is unowned.
- GNT is always one-hot or zero. GNT[k]=1 exactly when BUSY=1 and {S2,S1,S0}=k.

## Timing
- Reset (RST_N low, asynchronous): GNT=0x00, S2..S0=000, BUSY=0, PTR=0, CNT=0, state=IDLE. The reset takes effect immediately, including mid-tenure. The first grant can occur at the first rising edge after RST_N deasserts.
- Grant latency: REQ sampled at edge k produces GNT at edge k+1, i.e. one cycle.
- Release latency: REQ[o] or EN dropping at edge k produces the new GNT at edge k+1.
- Contested tenure is exactly MAX_HOLD cycles of GNT high.
- REQ changes during a grant's first cycle are honoured at the next edge. Simultaneous requests resolve only by circular order.
- All outputs are registered. There is no combinational path from REQ to GNT.

## Structure
- Package mux_arb_pkg holds:
  - NREQ=8, SEL_W=3, CNT_W=4;
  - state encoding ST_IDLE=1'b0, ST_OWN=1'b1;
  - a function onehot8(idx).
- Sub-module mux_rr_pick (combinational, around 40 lines):
  - Inputs: REQ[7:0], MASK_IDX[2:0] plus an enable for excluding that index, PTR[2:0].
  - Outputs: FOUND and IDX[2:0].
  - It is instantiated once and shared by the IDLE and handover paths.
- Top level contains the FSM, PTR, CNT and the output registers.

## Test plan
- Reset: assert RST_N=0 mid-tenure with GNT=0x10. GNT=0x00, S=000 and BUSY=0 immediately, without waiting for a clock edge. After release, REQ=0xFF is granted to index 0.
- Single requester: REQ=0x08 from IDLE. One cycle later GNT=0x08, S=011, BUSY=1, and this holds for 10 cycles. Dropping REQ gives GNT=0x00, BUSY=0 and S=011 at the next edge.
- Contention with wrap (MAX_HOLD=4): REQ=0x81 held, PTR=0.
  - GNT=0x01 for 4 cycles, then 0x80 (S=111) for 4 cycles with no bubble, then 0x01 again.
  - PTR sequence is 1, 0.
- Early handover: REQ=0x06, owner 1. REQ[1] drops in cycle 2, and the next cycle has GNT=0x04, CNT=1, with BUSY staying high.
- Enable: EN drops during GNT=0x20. The next edge gives GNT=0x00. With EN low and REQ=0xFF, no grant is issued. EN high then grants index 6 (PTR=6).
- Invariant check in all scenarios: GNT has at most one bit set, and it matches {S2,S1,S0} whenever BUSY=1.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared sizes, FSM encoding and one-hot helper for the mux arbiter
package mux_arb_pkg;
  localparam int NREQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;
  function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/grant bundle between requesters and the mux arbiter
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;
  logic en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic s2, s1, s0, busy;
  modport master (output en, req, input gnt, s2, s1, s0, busy);
  modport slave (input en, req, output gnt, s2, s1, s0, busy);
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// mux_rr_pick: circular first-set search from ptr, optionally excluding one index
module mux_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] mask_idx,
  input  logic             mask_en,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] j;
  // scan farthest-first so the candidate closest to ptr is written last
  always_comb begin
    found = 1'b0;
    idx = ptr;
    j = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = ptr + SEL_W'(k);
      if (req[j] && !(mask_en && j == mask_idx)) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared 8:1 mux with bounded contested tenure
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic rst_n,
  mux_rr_arbiter_if.slave bus
);
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel, sel_n, pick_idx, pick_ptr;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic found, own, at_max, rel, grant;
  assign own = state == ST_OWN;
  assign at_max = cnt == CNT_W'(MAX_HOLD);
  // while owning, search starts after the owner and excludes it: found means contention
  assign pick_ptr = own ? sel + 3'd1 : ptr;
  mux_rr_pick u_pick (
    .req(bus.req),
    .mask_idx(sel),
    .mask_en(own),
    .ptr(pick_ptr),
    .found(found),
    .idx(pick_idx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr <= '0;
      sel <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel <= sel_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    rel = own && (!bus.req[sel] || !bus.en || (at_max && found));
    grant = bus.en && found && (!own || rel);
    state_n = grant ? ST_OWN : (rel ? ST_IDLE : state);
    sel_n = grant ? pick_idx : sel;
    ptr_n = rel ? sel + 3'd1 : ptr;
    cnt_n = grant ? CNT_W'(1) : ((own && !at_max) ? cnt + 4'd1 : cnt);
  end
  always_comb begin
    bus.busy = own;
    bus.gnt = own ? onehot8(sel) : '0;
    {bus.s2, bus.s1, bus.s0} = sel;
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios for the round-robin mux arbiter (MAX_HOLD=4)
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  mux_rr_arbiter_if bus();
  mux_rr_arbiter #(.MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  wire [2:0] sel = {bus.s2, bus.s1, bus.s0};
  always @(negedge clk) begin
    total++;
    if ($countones(bus.gnt) > 1 || (bus.busy && bus.gnt !== (8'h01 << sel)) || (!bus.busy && bus.gnt !== 8'h00)) begin
      bad++;
      $display("FAIL invariant gnt=%h sel=%0d busy=%b", bus.gnt, sel, bus.busy);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 8'h00;
    bus.en = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (bus.gnt !== 8'h00 || sel !== 3'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_state got gnt=%h sel=%0d busy=%b", bus.gnt, sel, bus.busy); end
    bus.req = 8'h10;
    tick();
    total++; if (bus.gnt !== 8'h10) begin bad++; $display("FAIL rst_first_grant got=%h exp=10", bus.gnt); end
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (bus.gnt !== 8'h00) begin bad++; $display("FAIL rst_async_gnt got=%h exp=00", bus.gnt); end
    total++; if (sel !== 3'd0) begin bad++; $display("FAIL rst_async_sel got=%0d exp=0", sel); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", bus.busy); end
    #1;
    rst_n = 1'b1;
    bus.req = 8'hFF;
    tick();
    total++; if (bus.gnt !== 8'h01 || sel !== 3'd0) begin bad++; $display("FAIL rst_then_ff got gnt=%h sel=%0d exp 01/0", bus.gnt, sel); end
  endtask
  task automatic test_single();
    do_reset();
    bus.req = 8'h08;
    tick();
    total++; if (bus.gnt !== 8'h08 || sel !== 3'd3 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_grant got gnt=%h sel=%0d busy=%b", bus.gnt, sel, bus.busy); end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (bus.gnt !== 8'h08) begin bad++; $display("FAIL single_hold cyc=%0d got=%h exp=08", i, bus.gnt); end
    end
    bus.req = 8'h00;
    tick();
    total++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || sel !== 3'd3) begin bad++; $display("FAIL single_drop got gnt=%h busy=%b sel=%0d exp 00/0/3", bus.gnt, bus.busy, sel); end
  endtask
  task automatic test_contention();
    do_reset();
    bus.req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.gnt !== 8'h01) begin bad++; $display("FAIL cont_own0 cyc=%0d got=%h exp=01", i, bus.gnt); end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.gnt !== 8'h80 || sel !== 3'd7) begin bad++; $display("FAIL cont_own7 cyc=%0d got gnt=%h sel=%0d exp 80/7", i, bus.gnt, sel); end
      if (i == 0) begin
        total++; if (dut.ptr !== 3'd1 || dut.cnt !== 4'd1) begin bad++; $display("FAIL cont_ptr1 got ptr=%0d cnt=%0d exp 1/1", dut.ptr, dut.cnt); end
      end
    end
    tick();
    total++; if (bus.gnt !== 8'h01 || dut.ptr !== 3'd0) begin bad++; $display("FAIL cont_wrap got gnt=%h ptr=%0d exp 01/0", bus.gnt, dut.ptr); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    bus.req = 8'h06;
    tick();
    total++; if (bus.gnt !== 8'h02) begin bad++; $display("FAIL early_first got=%h exp=02", bus.gnt); end
    tick();
    bus.req = 8'h04;
    tick();
    total++; if (bus.gnt !== 8'h04 || dut.cnt !== 4'd1 || bus.busy !== 1'b1) begin bad++; $display("FAIL early_handover got gnt=%h cnt=%0d busy=%b exp 04/1/1", bus.gnt, dut.cnt, bus.busy); end
  endtask
  task automatic test_enable();
    do_reset();
    bus.req = 8'h20;
    tick();
    total++; if (bus.gnt !== 8'h20) begin bad++; $display("FAIL en_first got=%h exp=20", bus.gnt); end
    bus.en = 1'b0;
    tick();
    total++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || dut.ptr !== 3'd6) begin bad++; $display("FAIL en_drop got gnt=%h busy=%b ptr=%0d exp 00/0/6", bus.gnt, bus.busy, dut.ptr); end
    bus.req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.gnt !== 8'h00) begin bad++; $display("FAIL en_low_nogrant cyc=%0d got=%h exp=00", i, bus.gnt); end
    end
    bus.en = 1'b1;
    tick();
    total++; if (bus.gnt !== 8'h40 || sel !== 3'd6) begin bad++; $display("FAIL en_restore got gnt=%h sel=%0d exp 40/6", bus.gnt, sel); end
  endtask
  initial begin
    bus.en = 1'b1;
    bus.req = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
